// File: rtl/iter_shift_rev_pkg.sv
// Shared definitions for the iterative shift/rotate-right block:
// FSM state encoding, operation mode encodings and default sizing.
package iter_shift_rev_pkg;

  // Default data path width and matching shift-amount width (log2 of width)
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_AMT_W = 3;

  // Operation select encodings
  localparam logic MODE_SHR = 1'b0;  // logical shift right, zero fill at MSB
  localparam logic MODE_ROR = 1'b1;  // rotate right, old LSB refills MSB

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iter_shift_rev_shr_step.sv
// One-bit shift/rotate-right of a WIDTH-bit vector. Purely combinational;
// the controller applies it once per cycle to walk the operand into place.
module shr_step
  import iter_shift_rev_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic [WIDTH-1:0] dout
);

  logic fill_s;

  // Select the bit entering at the MSB, then move everything one place right
  always_comb begin
    fill_s = 1'b0;
    if (mode == MODE_ROR) begin
      fill_s = din[0];
    end else begin
      fill_s = 1'b0;
    end
    dout = {fill_s, din[WIDTH-1:1]};
  end

endmodule

// File: rtl/iter_shift_rev.sv
// Iterative shift/rotate-right unit. An accepted request is walked one bit
// per cycle through a work register; only the final value is published on
// dout, which otherwise holds the previous result.
module iter_shift_rev
  import iter_shift_rev_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = DEFAULT_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1'b1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] step_s;
  logic [AMT_W-1:0] cnt_r;
  logic             mode_r;
  logic [WIDTH-1:0] dout_r;
  logic             busy_r;
  logic             done_r;

  // One-bit step applied to the work register each SHIFT cycle
  shr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din  (work_r),
    .mode (mode_r),
    .dout (step_s)
  );

  // Next-state decode; start is only looked at in IDLE so it cannot queue
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (amt != CNT_ZERO) begin
            next_state_s = SHIFT;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        // Leave on the step that takes the counter from 1 to 0
        if (cnt_r == CNT_ONE) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Work register, counter, latched mode and published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r <= {WIDTH{1'b0}};
      cnt_r  <= CNT_ZERO;
      mode_r <= MODE_SHR;
      dout_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            work_r <= din;
            cnt_r  <= amt;
            mode_r <= mode;
            // Zero-count request completes immediately with the operand
            if (amt == CNT_ZERO) begin
              dout_r <= din;
            end
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - CNT_ONE;
          // Publish only the final step so intermediates never show
          if (cnt_r == CNT_ONE) begin
            dout_r <= step_s;
          end
        end
        DONE: begin
          work_r <= work_r;
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

  // Registered status flags derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s == SHIFT);
      done_r <= (next_state_s == DONE);
    end
  end

  assign dout = dout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_iter_shift_rev.sv
// Scoreboard bench for iter_shift_rev: stimulus pushes expected results and
// completion cycles; an independent monitor checks every cycle.
module tb_iter_shift_rev;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amt;
  logic             mode;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               done_cyc;
  } exp_t;

  exp_t             sb_q[$];
  int               cyc;
  int               busy_lo;
  int               busy_hi;
  logic [WIDTH-1:0] exp_hold;
  int               n_vec;
  int               n_err;

  iter_shift_rev #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .mode  (mode),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: shift/rotate computed arithmetically on a doubled operand
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                             input int a, input logic m);
    logic [2*WIDTH-1:0] dbl;
    if (m) dbl = {d, d};
    else   dbl = {{WIDTH{1'b0}}, d};
    dbl = dbl >> a;
    return dbl[WIDTH-1:0];
  endfunction

  // Issue one request; while it runs optionally throw junk at the inputs
  task automatic run_op(input logic [WIDTH-1:0] d, input int a, input logic m,
                        input logic [WIDTH-1:0] expv, input bit noise);
    exp_t e;
    start = 1'b1;
    din   = d;
    amt   = AMT_W'(a);
    mode  = m;
    @(posedge clk); #1;
    e.res      = expv;
    e.done_cyc = cyc + a;
    sb_q.push_back(e);
    busy_lo = cyc;
    busy_hi = cyc + a;
    for (int i = 0; i <= a; i++) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        din   = WIDTH'($urandom);
        amt   = AMT_W'($urandom);
        mode  = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Monitor: compares every post-edge sample against the scoreboard
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      if (!rst) begin
        chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc < busy_hi)));
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            chk("done_cycle", 32'(cyc), 32'(sb_q[0].done_cyc));
            chk("dout_result", 32'(dout), 32'(sb_q[0].res));
            exp_hold = sb_q[0].res;
            void'(sb_q.pop_front());
          end
        end else begin
          if (sb_q.size() != 0 && sb_q[0].done_cyc <= cyc) begin
            chk("missing_done", 32'(done), 32'd1);
            exp_hold = sb_q[0].res;
            void'(sb_q.pop_front());
          end
          chk("dout_hold", 32'(dout), 32'(exp_hold));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] rd;
    int               ra;
    logic             rm;
    n_vec    = 0;
    n_err    = 0;
    busy_lo  = 0;
    busy_hi  = 0;
    exp_hold = {WIDTH{1'b0}};
    start    = 1'b0;
    din      = {WIDTH{1'b0}};
    amt      = {AMT_W{1'b0}};
    mode     = 1'b0;
    rst      = 1'b1;
    #1;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived results
    run_op(8'hC3, 1, 1'b0, 8'h61, 1'b0);
    run_op(8'hC3, 5, 1'b0, 8'h06, 1'b0);
    run_op(8'hC3, 1, 1'b1, 8'hE1, 1'b0);
    run_op(8'hC3, 5, 1'b1, 8'h1E, 1'b0);
    run_op(8'hAA, 0, 1'b1, 8'hAA, 1'b0);
    // Junk start/din mid-operation, then an immediate back-to-back request
    run_op(8'hC3, 5, 1'b0, 8'h06, 1'b1);
    run_op(8'h81, 7, 1'b1, 8'h03, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a long SHIFT
    start = 1'b1; din = 8'h5A; amt = 3'd7; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_lo = cyc;
    busy_hi = cyc + 7;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    sb_q.delete();
    busy_hi  = busy_lo;
    exp_hold = {WIDTH{1'b0}};
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    run_op(8'h96, 3, 1'b1, 8'hD2, 1'b0);

    // Randomized requests, with occasional idle gaps and input noise
    for (int n = 0; n < 200; n++) begin
      rd = WIDTH'($urandom);
      ra = $urandom_range(0, WIDTH - 1);
      rm = 1'($urandom);
      run_op(rd, ra, rm, model(rd, ra, rm), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        din = WIDTH'($urandom);
        amt = AMT_W'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #3;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iter_shift_rev.md
ITER_SHIFT_REV -- requirements
Module: iter_shift_rev

Interface
REQ-001 Parameter WIDTH, default 8: data path width in bits.
REQ-002 Parameter AMT_W, default 3: shift-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request strobe, sampled on a rising clk edge.
REQ-006 din  input  WIDTH  operand, sampled with start.
REQ-007 amt  input  AMT_W  shift/rotate count 0..WIDTH-1, sampled with start.
REQ-008 mode  input  1  operation select, sampled with start: 0 = logical shift right (zero fill at MSB); 1 = rotate right.
REQ-009 dout  output  WIDTH  result register.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL load din into a work register, load amt into a down-counter and latch mode.
- Next state SHALL be SHIFT if amt!=0, otherwise DONE.
REQ-014 In SHIFT, each cycle SHALL move the work register one bit right and decrement the counter.
- mode=0: MSB filled with 0.
- mode=1: MSB filled with the old LSB.
REQ-015 The block SHALL leave SHIFT for DONE on the cycle in which the counter decrements from 1 to 0.
REQ-016 On entry to DONE, dout SHALL load the final work-register value.
- DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: done SHALL assert amt+1 cycles after the edge that accepts start.
- amt=0 gives a 1-cycle latency with dout=din.
REQ-018 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored in SHIFT and DONE; no queueing.
- din, amt and mode changes outside the accepting edge SHALL have no effect.
REQ-020 dout SHALL hold its value from DONE until the next completion.
- dout SHALL NOT change during SHIFT; intermediate values are never visible.
REQ-021 start asserted in the IDLE cycle that immediately follows DONE SHALL be accepted, giving back-to-back operations with no gap.
REQ-022 Result SHALL equal din>>amt (mode=0) or the right rotate of din by amt (mode=1), modulo WIDTH.

Reset
REQ-023 rst=1 SHALL force, without waiting for clk:
- state=IDLE, counter=0, work register=0;
- dout=0, busy=0, done=0.
REQ-024 Reset asserted mid-operation SHALL abort it, with no done pulse.
- After rst deasserts, the block SHALL accept the first start as a fresh operation.

Structure
REQ-025 A shared package SHALL hold:
- the FSM state enumeration (IDLE, SHIFT, DONE);
- the mode encodings MODE_SHR=0 and MODE_ROR=1;
- the default WIDTH constant.
REQ-026 A single combinational sub-module, shr_step, SHALL implement one-bit shift/rotate-right of a WIDTH vector selected by mode.
- iter_shift_rev SHALL contain the FSM, counter and registers.

Verification
REQ-027 din=11000011, amt=001, mode=0 -> done after 2 cycles, dout=01100001.
REQ-028 din=11000011, amt=101, mode=0 -> done after 6 cycles, dout=00000110; busy high for 5 cycles.
REQ-029 din=11000011, amt=001, mode=1 -> dout=11100001; din=11000011, amt=101, mode=1 -> dout=00011110.
REQ-030 din=10101010, amt=000, mode=1 -> done on the next cycle with dout=10101010 and busy never high.
REQ-031 Mid-operation start pulse with different din -> ignored, original result delivered. Then start in the cycle after done -> second operation accepted with no gap.
REQ-032 rst pulsed asynchronously (between edges) during SHIFT of amt=111 -> all outputs 0 immediately, no done pulse. Then a new start -> correct result.
